// File: rtl/dmem_axi_bridge_pkg.sv
// Shared types and AXI constants for the data-side LSU-to-AXI4 bridge.
package dmem_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AWW  = 3'd3,
    ST_B    = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/dmem_axi_bridge.sv
// Single-beat AXI4 bridge for one outstanding LSU load/store/fence.i request.
// Define DMEM_BRIDGE_WR_BUFFER_EN to post stores and retire B in the background.
module dmem_axi_bridge
  import dmem_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                re,
  input  logic                we,
  input  logic                fencei,
  input  logic                core_ready,
  input  logic [63:0]         data_pc,
  input  logic [DATA_W-1:0]   data_o,
  input  logic [DATA_W/8-1:0] wlen,
  input  logic [2:0]          data_size,
  output logic [DATA_W-1:0]   data_temp,
  output logic                data_valid,
  output logic                bus_err,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [2:0]          ar_size,
  output logic [7:0]          ar_len,
  output logic [1:0]          ar_burst,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [2:0]          aw_size,
  output logic [7:0]          aw_len,
  output logic [1:0]          aw_burst,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_last,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [1:0]          b_resp
);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] strb_q;
  logic [DATA_W-1:0]   data_temp_q;
  logic                bus_err_q;
  logic                ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;

  logic req, can_start, bg_err, aw_fin, w_fin, finishing;

  assign req    = re | we | fencei;
  assign aw_fin = ~aw_valid_q | aw_ready;
  assign w_fin  = ~w_valid_q | w_ready;

  generate
    if (ADDR_W < 64) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^data_pc[63:ADDR_W];
    end
  endgenerate

`ifdef DMEM_BRIDGE_WR_BUFFER_EN
  logic pending_q, err_pend_q;
  // A posted store's B may land in the same cycle another completion is reported.
  assign can_start = ~pending_q;
  assign bg_err    = err_pend_q | (pending_q & b_valid & resp_is_err(b_resp));
`else
  assign can_start = 1'b1;
  assign bg_err    = 1'b0;
`endif

  always_comb begin
    finishing = 1'b0;
    case (state_q)
      ST_IDLE: finishing = fencei & ~re & ~we & can_start;
      ST_R:    finishing = r_valid;
`ifdef DMEM_BRIDGE_WR_BUFFER_EN
      ST_AWW:  finishing = aw_fin & w_fin;
`endif
      ST_B:    finishing = b_valid;
      default: finishing = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      data_temp_q <= '0;
      bus_err_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
`ifdef DMEM_BRIDGE_WR_BUFFER_EN
      pending_q   <= 1'b0;
      err_pend_q  <= 1'b0;
`endif
    end else begin
`ifdef DMEM_BRIDGE_WR_BUFFER_EN
      if (pending_q && b_valid) begin
        pending_q  <= 1'b0;
        b_ready_q  <= 1'b0;
        err_pend_q <= err_pend_q | resp_is_err(b_resp);
      end
      if (finishing) err_pend_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req && can_start) begin
            addr_q  <= data_pc[ADDR_W-1:0];
            size_q  <= data_size;
            wdata_q <= data_o;
            strb_q  <= wlen;
            if (re) begin
              ar_valid_q <= 1'b1;
              state_q    <= ST_AR;
            end else if (we) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= ST_AWW;
            end else begin
              bus_err_q <= bg_err;
              state_q   <= ST_DONE;
            end
          end
        end
        ST_AR: begin
          if (ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= ST_R;
          end
        end
        ST_R: begin
          if (r_valid) begin
            r_ready_q   <= 1'b0;
            data_temp_q <= r_data;
            bus_err_q   <= resp_is_err(r_resp) | bg_err;
            state_q     <= ST_DONE;
          end
        end
        ST_AWW: begin
          if (aw_valid_q && aw_ready) aw_valid_q <= 1'b0;
          if (w_valid_q && w_ready) w_valid_q <= 1'b0;
          if (aw_fin && w_fin) begin
            b_ready_q <= 1'b1;
`ifdef DMEM_BRIDGE_WR_BUFFER_EN
            pending_q <= 1'b1;
            bus_err_q <= bg_err;
            state_q   <= ST_DONE;
`else
            state_q   <= ST_B;
`endif
          end
        end
        ST_B: begin
          if (b_valid) begin
            b_ready_q <= 1'b0;
            bus_err_q <= resp_is_err(b_resp) | bg_err;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (core_ready) begin
            bus_err_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_valid = (state_q == ST_AR) || (state_q == ST_R) || (state_q == ST_AWW) ||
                      (state_q == ST_B) || ((state_q == ST_IDLE) && req);

  assign data_temp = data_temp_q;
  assign bus_err   = bus_err_q;
  assign ar_valid  = ar_valid_q;
  assign ar_addr   = addr_q;
  assign ar_size   = size_q;
  assign ar_len    = LEN_SINGLE;
  assign ar_burst  = BURST_INCR;
  assign r_ready   = r_ready_q;
  assign aw_valid  = aw_valid_q;
  assign aw_addr   = addr_q;
  assign aw_size   = size_q;
  assign aw_len    = LEN_SINGLE;
  assign aw_burst  = BURST_INCR;
  assign w_valid   = w_valid_q;
  assign w_data    = wdata_q;
  assign w_strb    = strb_q;
  assign w_last    = 1'b1;
  assign b_ready   = b_ready_q;

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed bench for dmem_axi_bridge; AXI slave behaviour is scripted per scenario.
module tb_dmem_axi_bridge;
  import dmem_axi_bridge_pkg::*;

  logic        clk, rst;
  logic        re, we, fencei, core_ready;
  logic [63:0] data_pc, data_o;
  logic [7:0]  wlen;
  logic [2:0]  data_size;
  logic [63:0] data_temp;
  logic        data_valid, bus_err;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr, aw_addr;
  logic [2:0]  ar_size, aw_size;
  logic [7:0]  ar_len, aw_len;
  logic [1:0]  ar_burst, aw_burst;
  logic        r_valid, r_ready;
  logic [63:0] r_data, w_data;
  logic [1:0]  r_resp, b_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [7:0]  w_strb;

  int n_cmp = 0;
  int n_err = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

  dmem_axi_bridge #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .fencei(fencei), .core_ready(core_ready),
    .data_pc(data_pc), .data_o(data_o), .wlen(wlen), .data_size(data_size),
    .data_temp(data_temp), .data_valid(data_valid), .bus_err(bus_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_size(ar_size),
    .ar_len(ar_len), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_size(aw_size),
    .aw_len(aw_len), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (ar_valid && ar_ready) ar_cnt <= ar_cnt + 1;
      if (aw_valid && aw_ready) aw_cnt <= aw_cnt + 1;
      if (w_valid && w_ready)   w_cnt  <= w_cnt + 1;
      if (b_valid && b_ready)   b_cnt  <= b_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; re = 0; we = 0; fencei = 0; core_ready = 0;
    data_pc = '0; data_o = '0; wlen = '0; data_size = '0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", data_valid); end
    n_cmp++; if ({ar_valid, aw_valid, w_valid, r_ready, b_ready} !== 5'b0) begin n_err++;
      $display("FAIL rst_valids: got %b want 00000", {ar_valid, aw_valid, w_valid, r_ready, b_ready}); end
    n_cmp++; if (data_temp !== 64'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", data_temp); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus_err); end
    n_cmp++; if ({ar_len, ar_burst, aw_len, aw_burst, w_last} !== {8'd0, 2'b01, 8'd0, 2'b01, 1'b1}) begin n_err++;
      $display("FAIL axi_consts: got %h/%b/%h/%b/%b", ar_len, ar_burst, aw_len, aw_burst, w_last); end
    $display("reset done");
  endtask

  task automatic test_load();
    int a0;
    a0 = ar_cnt;
    ar_ready = 1; r_valid = 1; r_data = 64'h1122334455667788; r_resp = 2'b00;
    re = 1; data_pc = 64'h0000_0000_8000_0010; data_size = SIZE_D;
    #1;
    n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL ld_busy_req: got %b want 1", data_valid); end
    tick();
    n_cmp++; if (ar_valid !== 1'b1) begin n_err++; $display("FAIL ld_ar_valid: got %b want 1", ar_valid); end
    n_cmp++; if (ar_addr !== 32'h8000_0010) begin n_err++; $display("FAIL ld_ar_addr: got %h want 80000010", ar_addr); end
    n_cmp++; if (ar_size !== 3'd3) begin n_err++; $display("FAIL ld_ar_size: got %0d want 3", ar_size); end
    tick();
    n_cmp++; if ({r_ready, data_valid, ar_valid} !== 3'b110) begin n_err++;
      $display("FAIL ld_r_phase: got %b want 110", {r_ready, data_valid, ar_valid}); end
    tick();
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL ld_done_busy: got %b want 0", data_valid); end
    n_cmp++; if (data_temp !== 64'h1122334455667788) begin n_err++;
      $display("FAIL ld_data: got %h want 1122334455667788", data_temp); end
    n_cmp++; if ({bus_err, r_ready} !== 2'b00) begin n_err++; $display("FAIL ld_done_flags: got %b want 00", {bus_err, r_ready}); end
    r_valid = 0; re = 0; core_ready = 1;
    tick();
    core_ready = 0;
    n_cmp++; if (ar_cnt !== a0 + 1) begin n_err++; $display("FAIL ld_ar_count: got %0d want %0d", ar_cnt, a0 + 1); end
    $display("load addr=80000010 data=%h", data_temp);
  endtask

  task automatic test_store();
    int aw0, w0;
    aw0 = aw_cnt; w0 = w_cnt;
    aw_ready = 1; w_ready = 1; b_valid = 0; b_resp = 2'b00;
    we = 1; data_pc = 64'h0000_0000_8000_0003; data_size = SIZE_B; wlen = 8'h08; data_o = 64'h0000_0000_AB00_0000;
    tick();
    n_cmp++; if ({aw_valid, w_valid} !== 2'b11) begin n_err++; $display("FAIL st_valids: got %b want 11", {aw_valid, w_valid}); end
    n_cmp++; if (aw_addr !== 32'h8000_0003) begin n_err++; $display("FAIL st_aw_addr: got %h want 80000003", aw_addr); end
    n_cmp++; if (aw_size !== 3'd0) begin n_err++; $display("FAIL st_aw_size: got %0d want 0", aw_size); end
    n_cmp++; if (w_strb !== 8'h08) begin n_err++; $display("FAIL st_strb: got %h want 08", w_strb); end
    n_cmp++; if (w_data !== 64'h0000_0000_AB00_0000) begin n_err++; $display("FAIL st_wdata: got %h want ab000000", w_data); end
    tick();
    n_cmp++; if ({aw_valid, w_valid, b_ready, data_valid} !== 4'b0011) begin n_err++;
      $display("FAIL st_b_phase: got %b want 0011", {aw_valid, w_valid, b_ready, data_valid}); end
    tick();
    n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL st_wait_b: got %b want 1", data_valid); end
    b_valid = 1;
    tick();
    b_valid = 0;
    n_cmp++; if ({data_valid, b_ready, bus_err} !== 3'b000) begin n_err++;
      $display("FAIL st_done: got %b want 000", {data_valid, b_ready, bus_err}); end
    n_cmp++; if ({aw_cnt - aw0, w_cnt - w0} !== {32'd1, 32'd1}) begin n_err++;
      $display("FAIL st_beats: got aw=%0d w=%0d want 1/1", aw_cnt - aw0, w_cnt - w0); end
    we = 0; core_ready = 1;
    tick();
    core_ready = 0;
    $display("store addr=80000003 strb=08 data=ab000000");
  endtask

  task automatic test_aw_late();
    int aw0, w0;
    aw0 = aw_cnt; w0 = w_cnt;
    aw_ready = 0; w_ready = 1; b_valid = 0;
    we = 1; data_pc = 64'h0000_0000_8000_0100; data_size = SIZE_D; wlen = 8'hFF; data_o = 64'hCAFE_F00D_1234_5678;
    tick();
    n_cmp++; if ({aw_valid, w_valid} !== 2'b11) begin n_err++; $display("FAIL late_start: got %b want 11", {aw_valid, w_valid}); end
    data_pc = 64'h0000_0000_DEAD_BEE0;
    tick();
    n_cmp++; if ({aw_valid, w_valid} !== 2'b10) begin n_err++; $display("FAIL late_w_drop: got %b want 10", {aw_valid, w_valid}); end
    n_cmp++; if (aw_addr !== 32'h8000_0100) begin n_err++; $display("FAIL late_addr_hold: got %h want 80000100", aw_addr); end
    tick();
    n_cmp++; if ({aw_valid, b_ready} !== 2'b10) begin n_err++; $display("FAIL late_aw_hold: got %b want 10", {aw_valid, b_ready}); end
    aw_ready = 1;
    tick();
    n_cmp++; if ({aw_valid, w_valid, b_ready} !== 3'b001) begin n_err++;
      $display("FAIL late_to_b: got %b want 001", {aw_valid, w_valid, b_ready}); end
    b_valid = 1;
    tick();
    b_valid = 0;
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL late_done: got %b want 0", data_valid); end
    n_cmp++; if ({aw_cnt - aw0, w_cnt - w0} !== {32'd1, 32'd1}) begin n_err++;
      $display("FAIL late_beats: got aw=%0d w=%0d want 1/1", aw_cnt - aw0, w_cnt - w0); end
    we = 0; core_ready = 1;
    tick();
    core_ready = 0;
    $display("store aw_late addr=80000100 strb=ff");
  endtask

  task automatic test_rd_err();
    ar_ready = 1; r_valid = 1; r_data = 64'h0BAD_0BAD_0BAD_0BAD; r_resp = 2'b10;
    re = 1; data_pc = 64'h0000_0000_8000_0020; data_size = SIZE_W;
    tick(); tick(); tick();
    r_valid = 0; r_resp = 2'b00;
    n_cmp++; if ({bus_err, data_valid} !== 2'b10) begin n_err++; $display("FAIL rd_err_set: got %b want 10", {bus_err, data_valid}); end
    tick();
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL rd_err_hold: got %b want 1", bus_err); end
    re = 0; core_ready = 1;
    tick();
    core_ready = 0;
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rd_err_clear: got %b want 0", bus_err); end
    $display("load addr=80000020 resp=SLVERR");
  endtask

  task automatic test_done_hold();
    int a0;
    a0 = ar_cnt;
    ar_ready = 1; r_valid = 1; r_data = 64'h0102_0304_0506_0708; r_resp = 2'b00;
    re = 1; data_pc = 64'h0000_0000_8000_0040; data_size = SIZE_D;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({ar_valid, data_valid} !== 2'b00) begin n_err++;
        $display("FAIL hold_cyc%0d: got %b want 00", i, {ar_valid, data_valid}); end
      tick();
    end
    n_cmp++; if (ar_cnt !== a0 + 1) begin n_err++; $display("FAIL hold_ar_count: got %0d want %0d", ar_cnt, a0 + 1); end
    core_ready = 1;
    tick();
    core_ready = 0;
    n_cmp++; if ({data_valid, ar_valid} !== 2'b10) begin n_err++;
      $display("FAIL hold_reissue_idle: got %b want 10", {data_valid, ar_valid}); end
    tick();
    n_cmp++; if (ar_valid !== 1'b1) begin n_err++; $display("FAIL hold_reissue_ar: got %b want 1", ar_valid); end
    tick();
    re = 0;
    tick();
    r_valid = 0;
    n_cmp++; if (ar_cnt !== a0 + 2) begin n_err++; $display("FAIL hold_ar_total: got %0d want %0d", ar_cnt, a0 + 2); end
    core_ready = 1;
    tick();
    core_ready = 0;
    $display("load held in done, reissued addr=80000040");
  endtask

`ifdef DMEM_BRIDGE_WR_BUFFER_EN
  task automatic test_wrbuf();
    aw_ready = 1; w_ready = 1; b_valid = 0; b_resp = 2'b00;
    we = 1; data_pc = 64'h0000_0000_8000_0080; data_size = SIZE_D; wlen = 8'hFF; data_o = 64'h5555_AAAA_5555_AAAA;
    tick(); tick();
    n_cmp++; if ({data_valid, b_ready} !== 2'b01) begin n_err++; $display("FAIL wb_posted: got %b want 01", {data_valid, b_ready}); end
    we = 0; core_ready = 1;
    tick();
    core_ready = 0;
    ar_ready = 1; r_valid = 1; r_data = 64'h7777_6666_5555_4444; r_resp = 2'b00;
    re = 1; data_pc = 64'h0000_0000_8000_0088;
    tick();
    n_cmp++; if ({data_valid, ar_valid, b_ready} !== 3'b101) begin n_err++;
      $display("FAIL wb_stall: got %b want 101", {data_valid, ar_valid, b_ready}); end
    b_valid = 1; b_resp = 2'b10;
    tick();
    b_valid = 0; b_resp = 2'b00;
    n_cmp++; if (ar_valid !== 1'b0) begin n_err++; $display("FAIL wb_stall_b: got %b want 0", ar_valid); end
    tick();
    n_cmp++; if (ar_valid !== 1'b1) begin n_err++; $display("FAIL wb_ld_start: got %b want 1", ar_valid); end
    tick(); tick();
    r_valid = 0;
    n_cmp++; if ({data_valid, bus_err} !== 2'b01) begin n_err++; $display("FAIL wb_bg_err: got %b want 01", {data_valid, bus_err}); end
    re = 0; core_ready = 1;
    tick();
    core_ready = 0;
    $display("posted store addr=80000080 then load addr=80000088");
  endtask
`endif

  task automatic test_reset_mid();
    ar_ready = 1; r_valid = 0;
    re = 1; data_pc = 64'h0000_0000_8000_0100; data_size = SIZE_D;
    tick(); tick();
    n_cmp++; if (r_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_r: got %b want 1", r_ready); end
    rst = 1; re = 0;
    tick();
    rst = 0;
    n_cmp++; if ({ar_valid, r_ready, aw_valid, w_valid, b_ready, data_valid} !== 6'b0) begin n_err++;
      $display("FAIL rstmid_valids: got %b want 000000", {ar_valid, r_ready, aw_valid, w_valid, b_ready, data_valid}); end
    n_cmp++; if (data_temp !== 64'h0) begin n_err++; $display("FAIL rstmid_data: got %h want 0", data_temp); end
    $display("reset during read phase");
  endtask

  initial begin
    test_reset();
    test_load();
`ifndef DMEM_BRIDGE_WR_BUFFER_EN
    test_store();
    test_aw_late();
`endif
    test_rd_err();
    test_done_hold();
`ifdef DMEM_BRIDGE_WR_BUFFER_EN
    test_wrbuf();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_axi_bridge.md
Name: dmem_axi_bridge

Overview:
Data-side memory bridge directly downstream of the load/store unit. It takes one LSU request at a time (load, store or fence.i), runs a single-beat AXI4 read or write, and returns the raw 64-bit beat plus a busy flag to the LSU. The LSU does lane selection and sign extension; this block does none.

Parameters:
ADDR_W, 32, AXI address width; ar_addr/aw_addr = data_pc[ADDR_W-1:0]
DATA_W, 64, AXI data width; fixed, non-64 values unsupported

Ports:
clk  in  1  clock
rst  in  1  reset
re  in  1  load request, level, held by LSU until completion consumed
we  in  1  store request, level
fencei  in  1  fence.i request, level
core_ready  in  1  LSU/WB can take the completion
data_pc  in  64  byte address
data_o  in  64  store data, already lane-positioned
wlen  in  8  store byte strobes
data_size  in  3  AXI size code (0=B,1=H,2=W,3=D)
data_temp  out  64  last read beat, raw
data_valid  out  1  busy: 1 = request in flight, 0 = idle or done (data_temp valid)
bus_err  out  1  completion carried non-OKAY resp
ar_valid  out  1  read address valid
ar_ready  in  1  read address ready
ar_addr  out  ADDR_W  read address
ar_size  out  3  read size
r_valid  in  1  read data valid
r_ready  out  1  read data ready
r_data  in  64  read data
r_resp  in  2  read response
aw_valid  out  1  write address valid
aw_ready  in  1  write address ready
aw_addr  out  ADDR_W  write address
aw_size  out  3  write size
w_valid  out  1  write data valid
w_ready  in  1  write data ready
w_data  out  64  write data = data_o
w_strb  out  8  write strobes = wlen
b_valid  in  1  write response valid
b_ready  out  1  write response ready
b_resp  in  2  write response

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset puts FSM in IDLE and clears data_temp, bus_err and all valid/ready outputs to 0. Reset in mid-transaction drops channel valids immediately; this is allowed only under system-wide reset.
- AXI constants, tied at top level: len=0, burst=INCR, w_last=1.
- req = re|we|fencei. Priority when several are asserted (illegal): re > we > fencei.
- data_valid is combinational: 1 when state is AR, R, AWW or B, or when state is IDLE and req=1. The LSU therefore sees busy in the cycle of the request.
- State IDLE, req=1: latch address, size, wdata and strb.
  - re -> AR.
  - we -> AWW.
  - fencei -> DONE. No bus traffic; data_temp is unchanged.
- AR: ar_valid=1 until ar_ready, then -> R.
- R: r_ready=1. On r_valid, capture data_temp=r_data and bus_err=(r_resp!=0), then -> DONE.
- AWW: aw_valid and w_valid are raised together and dropped independently on their own handshakes; the two handshakes may land in any order. When both are done -> B.
- B: b_ready=1. On b_valid, set bus_err=(b_resp!=0), then -> DONE.
- DONE: data_valid=0 and outputs held. If core_ready=1 -> IDLE next cycle. A request still present in IDLE is treated as a new request (the LSU drops it once consumed).
- Minimum latency, with ready signals always high:
  - Load: request at cycle T, ar_valid at T+1, r handshake at T+2 at the earliest, data_valid=0 from T+3.
  - Store: aw/w handshakes at T+1, b handshake at T+2 at the earliest, data_valid=0 from T+3.
- bus_err is cleared on leaving DONE. No retry on error.
- Request inputs are ignored outside IDLE. Latched address and data stay stable while channel valids are high (AXI rule).

Optional Feature:
DMEM_BRIDGE_WR_BUFFER_EN
- When defined: stores are posted. After both AW and W are accepted -> DONE without waiting for B. The B response is consumed in the background via a pending flag. A new load or store in IDLE stalls (data_valid=1) until pending clears; fence.i also waits for pending to clear. A background b_resp error sets bus_err on the next completion.
- When undefined: stores wait for B as specified above.

Decomposition:
- Shared package: FSM state encoding (IDLE, AR, R, AWW, B, DONE), AXI resp codes (OKAY=0), burst constant INCR=2'b01, size codes.
- No sub-module; one FSM with a small datapath register set.

Test Plan:
- ld at 0x8000_0010, size 3, r_data=0x1122334455667788, OKAY -> ar_addr=0x80000010, ar_size=3; data_temp equals beat; data_valid falls in the cycle after the r handshake.
- sb at 0x8000_0003, wlen=0x08, data_o=0xAB000000 -> aw_addr=0x80000003, aw_size=0, w_strb=0x08, w_data=0xAB000000; completion only after B.
- Store with aw_ready 3 cycles late and w_ready immediate -> w_valid drops after 1 cycle, aw_valid holds 3 cycles, exactly one AW and one W beat issued.
- r_resp=2'b10 on a load -> bus_err=1 in DONE; clears after core_ready.
- core_ready=0 for 4 cycles in DONE with re still high -> no new AR issued; next AR only after return to IDLE.
- rst asserted while in R -> next cycle all valids 0, data_valid=0, data_temp=0; with DMEM_BRIDGE_WR_BUFFER_EN, store completes before B and a following load stalls until b_valid.
